// File: rtl/int_arb_pkg.sv
// Shared definitions for the external interrupt request arbiter:
// FSM state encoding, cfg_sel encodings, default vector base and the
// vector-number helper used by the top level.
package int_arb_pkg;

  // Arbiter FSM state encoding (also visible on the debug state output)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  // cfg_sel encodings
  localparam logic CFG_SEL_MASK = 1'b0;  // replace the enable mask in full
  localparam logic CFG_SEL_W1C  = 1'b1;  // clear pending bits written as 1

  // Interrupt number of source 0 unless overridden
  localparam logic [7:0] DEFAULT_VEC_BASE = 8'h20;

  // Width of a source index (up to 32 sources)
  localparam int IDX_W = 5;

  // Interrupt number for a source index, wrapping at 8 bits
  function automatic logic [7:0] vec_num(input logic [7:0] base,
                                         input logic [IDX_W-1:0] idx);
    return base + {3'b000, idx};
  endfunction

endpackage

// File: rtl/int_prio_pick.sv
// Combinational priority picker. Searches the candidate vector starting at
// i_start and wrapping around; the first set bit found wins. With i_start
// tied to 0 it degenerates to a plain lowest-index-wins picker.
// The wrap is done without arithmetic: candidates at or above the start
// index are searched first, and only if none exist is the full vector
// searched from index 0.
module int_prio_pick
  import int_arb_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0] i_cand,
  input  logic [IDX_W-1:0]   i_start,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_hi_valid;
  logic [IDX_W-1:0] w_hi_idx;
  logic             w_lo_valid;
  logic [IDX_W-1:0] w_lo_idx;

  // Lowest set bit at/above start, and lowest set bit overall
  always_comb begin
    w_hi_valid = 1'b0;
    w_hi_idx   = '0;
    w_lo_valid = 1'b0;
    w_lo_idx   = '0;
    // Descending scan: the last hit assigned is the lowest index
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_cand[i]) begin
        w_lo_valid = 1'b1;
        w_lo_idx   = IDX_W'(i);
        if (i >= int'(i_start)) begin
          w_hi_valid = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Prefer the upper (post-start) region, otherwise wrap to the bottom
  always_comb begin
    o_valid = w_lo_valid;
    o_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/int_request_arbiter.sv
// External interrupt request arbiter.
// Latches rising edges of the irq lines into pending bits, masks them with
// the enable register, and presents one winner at a time to the interrupt
// core. Optional feature: define INT_ARB_RR_EN for round-robin arbitration
// (search starts just after the last accepted source); without it the
// lowest-index candidate wins and no round-robin pointer exists.
//
// Request/accept handshake with the interrupt core:
//   int_sign_external acts as valid and la_ta_ask as ready. While
//   int_sign_external is high, int_num_external is held stable and the
//   winner is never re-arbitrated. A cycle in which int_sign_external=1 and
//   la_ta_ask=1 is the accept: the winner's pending bit clears and the
//   arbiter waits in BUSY until la_ta_ask drops. Before accept, a config
//   write that disables or W1C-clears the winner withdraws the request
//   (int_sign_external drops the next cycle). la_ta_ask high while idle
//   means the core is busy with an internal interrupt; no request is
//   raised until it drops.
module int_request_arbiter
  import int_arb_pkg::*;
#(
  parameter int         NUM_SRC  = 16,
  parameter logic [7:0] VEC_BASE = DEFAULT_VEC_BASE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               cfg_we,
  input  logic               cfg_sel,
  input  logic [31:0]        cfg_wdata,
  input  logic               la_ta_ask,
  output logic               int_sign_external,
  output logic [7:0]         int_num_external,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] enable,
  output logic [IDX_W-1:0]   active_id,
  output logic [1:0]         dbg_state
);

  // State registers
  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_win_idx;
  logic [7:0]         r_num;
  logic [IDX_W-1:0]   r_active_id;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_irq_prev;
  logic               r_primed;

  // Combinational signals
  logic [1:0]         w_state_nxt;
  logic               w_load_win;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_win_bit;
  logic [NUM_SRC-1:0] w_w1c_bits;
  logic [NUM_SRC-1:0] w_acc_bits;
  logic               w_cfg_mask_wr;
  logic               w_cfg_w1c_wr;
  logic               w_accept;
  logic               w_withdraw;
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_start;
  logic               w_cfg_unused;

  // Config data above NUM_SRC-1 has no effect
  assign w_cfg_unused = ^cfg_wdata;

  assign w_cand        = r_pending & r_enable;
  // No edge is reported on the first sampled cycle after reset
  assign w_edge        = irq & ~r_irq_prev & {NUM_SRC{r_primed}};
  assign w_win_bit     = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_win_idx;
  assign w_cfg_mask_wr = cfg_we && (cfg_sel == CFG_SEL_MASK);
  assign w_cfg_w1c_wr  = cfg_we && (cfg_sel == CFG_SEL_W1C);
  assign w_w1c_bits    = w_cfg_w1c_wr ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign w_accept      = (r_state == ST_REQ) && la_ta_ask;
  assign w_acc_bits    = w_accept ? w_win_bit : '0;
  // The winner is taken away by a mask write with its bit 0 or a W1C
  // write with its bit 1
  assign w_withdraw    = (r_state == ST_REQ) &&
                         ((w_cfg_mask_wr && !cfg_wdata[r_win_idx]) ||
                          (w_cfg_w1c_wr  &&  cfg_wdata[r_win_idx]));

`ifdef INT_ARB_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;

  // Round-robin search start: one past the last accepted source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= IDX_W'(1);
    end else if (w_accept) begin
      r_rr_ptr <= (r_win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_win_idx + IDX_W'(1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  int_prio_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .i_cand  (w_cand),
    .i_start (w_start),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Next-state logic of the IDLE/REQ/BUSY arbiter FSM
  always_comb begin
    w_state_nxt = r_state;
    w_load_win  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!la_ta_ask && w_pick_valid) begin
          w_state_nxt = ST_REQ;
          w_load_win  = 1'b1;
        end
      end
      ST_REQ: begin
        if (w_accept) begin
          w_state_nxt = ST_BUSY;
        end else if (w_withdraw) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!la_ta_ask) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, latched winner/number and last accepted source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_win_idx   <= '0;
      r_num       <= '0;
      r_active_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_win) begin
        r_win_idx <= w_pick_idx;
        r_num     <= vec_num(VEC_BASE, w_pick_idx);
      end
      if (w_accept) begin
        r_active_id <= r_win_idx;
      end
    end
  end

  // Pending bits: clears from accept and W1C first, a new edge wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_w1c_bits & ~w_acc_bits) | w_edge;
    end
  end

  // Enable mask register, replaced in full by a mask write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= '0;
    end else if (w_cfg_mask_wr) begin
      r_enable <= cfg_wdata[NUM_SRC-1:0];
    end
  end

  // Previous-sample registers for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_prev <= '0;
      r_primed   <= 1'b0;
    end else begin
      r_irq_prev <= irq;
      r_primed   <= 1'b1;
    end
  end

  assign int_sign_external = (r_state == ST_REQ);
  assign int_num_external  = r_num;
  assign pending           = r_pending;
  assign enable            = r_enable;
  assign active_id         = r_active_id;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_int_request_arbiter.sv
// Bench for int_request_arbiter: directed scenarios with fixed expected
// values plus randomized traffic compared every cycle against a
// cycle-level behavioural model.
module tb_int_request_arbiter;

  localparam int         N   = 16;
  localparam logic [7:0] VEC = 8'h20;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_BUSY = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic          cfg_we;
  logic          cfg_sel;
  logic [31:0]   cfg_wdata;
  logic          la_ta_ask;
  logic          int_sign_external;
  logic [7:0]    int_num_external;
  logic [N-1:0]  pending;
  logic [N-1:0]  enable;
  logic [4:0]    active_id;
  logic [1:0]    dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  logic [31:0] m_pend;
  logic [31:0] m_en;
  logic [31:0] m_prev;
  bit          m_primed;
  int          m_mode;
  int          m_win;
  int          m_act;

  int_request_arbiter #(
    .NUM_SRC  (N),
    .VEC_BASE (VEC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .irq               (irq),
    .cfg_we            (cfg_we),
    .cfg_sel           (cfg_sel),
    .cfg_wdata         (cfg_wdata),
    .la_ta_ask         (la_ta_ask),
    .int_sign_external (int_sign_external),
    .int_num_external  (int_num_external),
    .pending           (pending),
    .enable            (enable),
    .active_id         (active_id),
    .dbg_state         (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pend   = '0;
    m_en     = '0;
    m_prev   = '0;
    m_primed = 1'b0;
    m_mode   = M_IDLE;
    m_win    = 0;
    m_act    = 0;
  endtask

  task automatic model_step();
    logic [31:0] e;
    logic [31:0] clr;
    logic [31:0] irq32;
    int start;
    int pick;
    int idx;
    irq32 = 32'(irq);
    e     = m_primed ? (irq32 & ~m_prev) : 32'd0;
    clr   = '0;
    if (cfg_we && cfg_sel) clr = cfg_wdata & 32'h0000FFFF;
    case (m_mode)
      M_IDLE: begin
        if (!la_ta_ask) begin
`ifdef INT_ARB_RR_EN
          start = (m_act + 1) % N;
`else
          start = 0;
`endif
          pick = -1;
          for (int k = 0; k < N; k++) begin
            idx = (start + k) % N;
            if (pick < 0 && m_pend[idx] && m_en[idx]) pick = idx;
          end
          if (pick >= 0) begin
            m_win  = pick;
            m_mode = M_REQ;
          end
        end
      end
      M_REQ: begin
        if (la_ta_ask) begin
          clr[m_win] = 1'b1;
          m_act      = m_win;
          m_mode     = M_BUSY;
        end else if (cfg_we && (cfg_sel ? cfg_wdata[m_win] : !cfg_wdata[m_win])) begin
          m_mode = M_IDLE;
        end
      end
      M_BUSY: begin
        if (!la_ta_ask) m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | e;
    if (cfg_we && !cfg_sel) m_en = cfg_wdata & 32'h0000FFFF;
    m_prev   = irq32;
    m_primed = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // scoreboard: compare DUT against model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("m_sign", 32'(int_sign_external), 32'(m_mode == M_REQ));
      if (m_mode == M_REQ) chk("m_num", 32'(int_num_external), (32'(VEC) + 32'(m_win)) & 32'hFF);
      chk("m_pend", 32'(pending), m_pend);
      chk("m_en", 32'(enable), m_en);
      chk("m_act", 32'(active_id), 32'(m_act));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] irq_hold);
    rst_n     = 1'b0;
    irq       = irq_hold;
    cfg_we    = 1'b0;
    cfg_sel   = 1'b0;
    cfg_wdata = '0;
    la_ta_ask = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg_write(input logic sel, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic accept();
    la_ta_ask = 1'b1;
    tick();
    la_ta_ask = 1'b0;
    tick();
  endtask

  task automatic wait_sign(input string tag, input int budget);
    int n;
    n = 0;
    while (int_sign_external !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(int_sign_external), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] first_num;
    logic [7:0] second_num;
    logic [4:0] last_id;
    int ask_hold;

    rst_n = 1'b0; irq = '0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_wdata = '0; la_ta_ask = 1'b0;
    #3;
    chk("rst_sign", 32'(int_sign_external), 0);
    chk("rst_num", 32'(int_num_external), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_en", 32'(enable), 0);
    chk("rst_act", 32'(active_id), 0);
    chk("rst_state", 32'(dbg_state), 0);

    // irq already high at reset release is not an edge
    do_reset(16'hFFFF);
    tick(); tick();
    chk("hi_at_rel_pend", 32'(pending), 0);
    chk("hi_at_rel_sign", 32'(int_sign_external), 0);

    // basic request, 2-cycle latency, 3-cycle ask pulse
    do_reset('0);
    cfg_write(1'b0, 32'h0001);
    irq[0] = 1'b1;
    tick();
    chk("b_sign_early", 32'(int_sign_external), 0);
    tick();
    chk("b_sign", 32'(int_sign_external), 1);
    chk("b_num", 32'(int_num_external), 32'h20);
    la_ta_ask = 1'b1;
    repeat (3) tick();
    la_ta_ask = 1'b0;
    chk("b_pend0", 32'(pending[0]), 0);
    chk("b_sign_low", 32'(int_sign_external), 0);
    chk("b_act", 32'(active_id), 0);
    tick(); tick();
    chk("b_idle", 32'(dbg_state), 0);

    // two simultaneous edges after source 4 was last accepted
`ifdef INT_ARB_RR_EN
    first_num = 8'h25; second_num = 8'h23; last_id = 5'd3;
`else
    first_num = 8'h23; second_num = 8'h25; last_id = 5'd5;
`endif
    do_reset('0);
    cfg_write(1'b0, 32'hFFFF);
    irq = 16'h0010;
    tick(); tick();
    chk("p_num4", 32'(int_num_external), 32'h24);
    accept();
    irq = 16'h0028;
    tick(); tick();
    chk("p_sign1", 32'(int_sign_external), 1);
    chk("p_num1", 32'(int_num_external), 32'(first_num));
    accept();
    tick();
    chk("p_sign2", 32'(int_sign_external), 1);
    chk("p_num2", 32'(int_num_external), 32'(second_num));
    accept();
    chk("p_act", 32'(active_id), 32'(last_id));
    chk("p_pend", 32'(pending), 0);

    // masked source latches pending, request follows enable
    do_reset('0);
    irq = 16'h0080;
    tick(); tick();
    chk("m_pend7", 32'(pending), 32'h80);
    chk("m_nosign", 32'(int_sign_external), 0);
    cfg_write(1'b0, 32'h0080);
    wait_sign("m_wait", 2);
    chk("m_num7", 32'(int_num_external), 32'h27);
    accept();

    // withdraw by W1C while in REQ
    do_reset('0);
    cfg_write(1'b0, 32'hFFFF);
    irq = 16'h0004;
    tick(); tick();
    chk("w_num", 32'(int_num_external), 32'h22);
    cfg_write(1'b1, 32'h4);
    chk("w_sign", 32'(int_sign_external), 0);
    chk("w_state", 32'(dbg_state), 0);
    chk("w_pend", 32'(pending), 0);
    chk("w_act", 32'(active_id), 0);
    tick();
    chk("w_sign2", 32'(int_sign_external), 0);

    // new edge during the accept cycle keeps pending set
    do_reset('0);
    cfg_write(1'b0, 32'hFFFF);
    irq = 16'h0004;
    tick(); tick();
    irq = '0;
    tick();
    la_ta_ask = 1'b1;
    irq = 16'h0004;
    tick();
    chk("s_pend2", 32'(pending[2]), 1);
    chk("s_act", 32'(active_id), 2);
    la_ta_ask = 1'b0;
    tick(); tick();
    chk("s_sign", 32'(int_sign_external), 1);
    chk("s_num", 32'(int_num_external), 32'h22);
    accept();

    // reset while BUSY with pending bits set
    do_reset('0);
    cfg_write(1'b0, 32'hFFFF);
    irq = 16'h0001;
    tick(); tick();
    chk("r_num0", 32'(int_num_external), 32'h20);
    la_ta_ask = 1'b1;
    irq = 16'h0031;
    tick(); tick();
    chk("r_busy", 32'(dbg_state), 2);
    chk("r_pend", 32'(pending), 32'h30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_sign", 32'(int_sign_external), 0);
    chk("r_num", 32'(int_num_external), 0);
    chk("r_pend0", 32'(pending), 0);
    chk("r_en0", 32'(enable), 0);
    chk("r_act0", 32'(active_id), 0);
    la_ta_ask = 1'b0;
    irq = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("r_pend_rel", 32'(pending), 0);

    // randomized traffic against the model
    do_reset('0);
    cfg_write(1'b0, 32'hFFFF);
    ask_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      irq = irq ^ N'($urandom & $urandom & $urandom & $urandom);
      if (ask_hold > 0) begin
        la_ta_ask = 1'b1;
        ask_hold--;
      end else if ($urandom_range(0, 5) == 0) begin
        la_ta_ask = 1'b1;
        ask_hold  = $urandom_range(0, 3);
      end else begin
        la_ta_ask = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) begin
        cfg_we    = 1'b1;
        cfg_sel   = 1'($urandom_range(0, 1));
        cfg_wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF : $urandom;
      end else begin
        cfg_we    = 1'b0;
        cfg_wdata = '0;
      end
      tick();
    end
    cfg_we = 1'b0;
    la_ta_ask = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
